// File: rtl/nonce_scheduler.sv
// Job-level nonce search controller: carves the 32-bit nonce space into chunks for NUM_WORKERS engines.
// Optional `NONCE_SCHED_STATS_EN adds the stat_chunks start counter output.
module nonce_scheduler #(
  parameter int unsigned NUM_WORKERS = 4,
  parameter int unsigned CHUNK_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [7:0]                job_diff,
  input  logic                      abort,
  output logic [NUM_WORKERS-1:0]    wk_start,
  output logic [31:0]               wk_base,
  output logic [7:0]                wk_diff,
  output logic                      wk_stop,
  input  logic [NUM_WORKERS-1:0]    wk_done,
  input  logic [NUM_WORKERS-1:0]    wk_found,
  input  logic [32*NUM_WORKERS-1:0] wk_nonce,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_found,
  output logic [31:0]               res_nonce,
`ifdef NONCE_SCHED_STATS_EN
  output logic [31:0]               stat_chunks,
`endif
  output logic                      busy
);

  localparam int unsigned SUM_W = 33;
  localparam logic [SUM_W-1:0] CHUNK_INC = SUM_W'(1) << CHUNK_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

  state_t                 state_q, state_nxt;
  logic [NUM_WORKERS-1:0] busy_q, busy_nxt;
  logic [31:0]            next_base_q, next_base_nxt;
  logic                   exhausted_q, exhausted_nxt;
  logic                   aborted_q, aborted_nxt;
  logic                   job_ready_q, job_ready_nxt;
  logic [NUM_WORKERS-1:0] wk_start_q, wk_start_nxt;
  logic [31:0]            wk_base_q, wk_base_nxt;
  logic [7:0]             wk_diff_q, wk_diff_nxt;
  logic                   wk_stop_q, wk_stop_nxt;
  logic                   res_valid_q, res_valid_nxt;
  logic                   res_found_q, res_found_nxt;
  logic [31:0]            res_nonce_q, res_nonce_nxt;

  logic                   job_accept;
  logic [NUM_WORKERS-1:0] busy_clr;
  logic [NUM_WORKERS-1:0] found_vec;
  logic [31:0]            found_nonce;
  logic                   dispatch_en;
  logic [NUM_WORKERS-1:0] busy_cur;
  logic [31:0]            base_cur;
  logic                   exh_cur;
  logic [NUM_WORKERS-1:0] idle_oh;
  logic [SUM_W-1:0]       base_sum;

  assign job_accept = (state_q == S_IDLE) && job_valid && job_ready_q;
  assign busy_clr   = busy_q & ~wk_done;
  assign found_vec  = wk_done & wk_found & busy_q;

  // Lowest-index golden nonce wins a same-cycle tie
  always_comb begin
    found_nonce = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (found_vec[i]) found_nonce = wk_nonce[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt     = state_q;
    busy_nxt      = busy_clr;
    next_base_nxt = next_base_q;
    exhausted_nxt = exhausted_q;
    aborted_nxt   = aborted_q;
    wk_start_nxt  = '0;
    wk_base_nxt   = wk_base_q;
    wk_diff_nxt   = wk_diff_q;
    res_found_nxt = res_found_q;
    res_nonce_nxt = res_nonce_q;
    dispatch_en   = 1'b0;
    busy_cur      = busy_clr;
    base_cur      = next_base_q;
    exh_cur       = exhausted_q;

    case (state_q)
      S_IDLE: begin
        busy_nxt = '0;
        busy_cur = '0;
        if (job_accept) begin
          wk_diff_nxt   = job_diff;
          base_cur      = '0;
          exh_cur       = 1'b0;
          next_base_nxt = '0;
          exhausted_nxt = 1'b0;
          aborted_nxt   = 1'b0;
          res_found_nxt = 1'b0;
          dispatch_en   = 1'b1;
          state_nxt     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_DRAIN;
        end else if (|found_vec) begin
          res_found_nxt = 1'b1;
          res_nonce_nxt = found_nonce;
          state_nxt     = S_DRAIN;
        end else if (exhausted_q && (busy_clr == '0)) begin
          res_found_nxt = 1'b0;
          res_nonce_nxt = '1;
          state_nxt     = S_REPORT;
        end else begin
          dispatch_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (busy_clr == '0) state_nxt = aborted_q ? S_IDLE : S_REPORT;
      end
      S_REPORT: begin
        if (abort || res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Start the lowest-index idle worker; a carry out of bit 31 ends the search space
    idle_oh  = ~busy_cur & (busy_cur + NUM_WORKERS'(1));
    base_sum = {1'b0, base_cur} + CHUNK_INC;
    if (dispatch_en && !exh_cur && (idle_oh != '0)) begin
      wk_start_nxt  = idle_oh;
      wk_base_nxt   = base_cur;
      busy_nxt      = busy_cur | idle_oh;
      next_base_nxt = base_sum[31:0];
      exhausted_nxt = base_sum[32];
    end

    job_ready_nxt = (state_nxt == S_IDLE);
    wk_stop_nxt   = (state_nxt == S_DRAIN);
    res_valid_nxt = (state_nxt == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      next_base_q <= '0;
      exhausted_q <= 1'b0;
      aborted_q   <= 1'b0;
      job_ready_q <= 1'b0;
      wk_start_q  <= '0;
      wk_base_q   <= '0;
      wk_diff_q   <= '0;
      wk_stop_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_nonce_q <= '0;
    end else begin
      state_q     <= state_nxt;
      busy_q      <= busy_nxt;
      next_base_q <= next_base_nxt;
      exhausted_q <= exhausted_nxt;
      aborted_q   <= aborted_nxt;
      job_ready_q <= job_ready_nxt;
      wk_start_q  <= wk_start_nxt;
      wk_base_q   <= wk_base_nxt;
      wk_diff_q   <= wk_diff_nxt;
      wk_stop_q   <= wk_stop_nxt;
      res_valid_q <= res_valid_nxt;
      res_found_q <= res_found_nxt;
      res_nonce_q <= res_nonce_nxt;
    end
  end

`ifdef NONCE_SCHED_STATS_EN
  logic [31:0] stat_q;

  // Counts start pulses as they appear on wk_start, saturating
  always_ff @(posedge clk) begin
    if (rst || job_accept) begin
      stat_q <= '0;
    end else if ((|wk_start_q) && (stat_q != '1)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_chunks = stat_q;
`endif

  assign job_ready = job_ready_q;
  assign wk_start  = wk_start_q;
  assign wk_base   = wk_base_q;
  assign wk_diff   = wk_diff_q;
  assign wk_stop   = wk_stop_q;
  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_nonce = res_nonce_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: instance a uses 16-bit chunks, instance b uses 30-bit chunks.
module tb_nonce_scheduler;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, job_valid, abort, res_ready;
  logic [7:0]      job_diff;
  logic [NW-1:0]   wk_done, wk_found;
  logic [32*NW-1:0] wk_nonce;

  logic a_job_ready, a_wk_stop, a_res_valid, a_res_found, a_busy;
  logic [NW-1:0] a_wk_start;
  logic [31:0] a_wk_base, a_res_nonce;
  logic [7:0] a_wk_diff;
  logic b_job_ready, b_wk_stop, b_res_valid, b_res_found, b_busy;
  logic [NW-1:0] b_wk_start;
  logic [31:0] b_wk_base, b_res_nonce;
  logic [7:0] b_wk_diff;
`ifdef NONCE_SCHED_STATS_EN
  logic [31:0] a_stat, b_stat;
`endif

  nonce_scheduler #(.NUM_WORKERS(NW), .CHUNK_BITS(16)) u_a (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(a_job_ready), .job_diff(job_diff),
    .abort(abort), .wk_start(a_wk_start), .wk_base(a_wk_base), .wk_diff(a_wk_diff),
    .wk_stop(a_wk_stop), .wk_done(wk_done), .wk_found(wk_found), .wk_nonce(wk_nonce),
    .res_valid(a_res_valid), .res_ready(res_ready), .res_found(a_res_found),
    .res_nonce(a_res_nonce),
`ifdef NONCE_SCHED_STATS_EN
    .stat_chunks(a_stat),
`endif
    .busy(a_busy)
  );

  nonce_scheduler #(.NUM_WORKERS(NW), .CHUNK_BITS(30)) u_b (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(b_job_ready), .job_diff(job_diff),
    .abort(abort), .wk_start(b_wk_start), .wk_base(b_wk_base), .wk_diff(b_wk_diff),
    .wk_stop(b_wk_stop), .wk_done(wk_done), .wk_found(wk_found), .wk_nonce(wk_nonce),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_found(b_res_found),
    .res_nonce(b_res_nonce),
`ifdef NONCE_SCHED_STATS_EN
    .stat_chunks(b_stat),
`endif
    .busy(b_busy)
  );

  typedef struct {
    logic [NW-1:0] done;
    logic [NW-1:0] start_a;
    logic [31:0]   base_a;
    logic [NW-1:0] start_b;
    logic [31:0]   base_b;
  } vec_t;

  vec_t tbl[7];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input bit use_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((use_b ? b_res_valid : a_res_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic accept_job(input logic [7:0] diff);
    job_valid = 1'b1;
    job_diff  = diff;
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int nstarts;
    bit rdy_seen;

    tbl[0] = '{4'b0000, 4'b0001, 32'h0000_0000, 4'b0001, 32'h0000_0000};
    tbl[1] = '{4'b0000, 4'b0010, 32'h0001_0000, 4'b0010, 32'h4000_0000};
    tbl[2] = '{4'b0000, 4'b0100, 32'h0002_0000, 4'b0100, 32'h8000_0000};
    tbl[3] = '{4'b0000, 4'b1000, 32'h0003_0000, 4'b1000, 32'hC000_0000};
    tbl[4] = '{4'b0010, 4'b0000, 32'h0,         4'b0000, 32'h0};
    tbl[5] = '{4'b0000, 4'b0010, 32'h0004_0000, 4'b0000, 32'h0};
    tbl[6] = '{4'b0000, 4'b0000, 32'h0,         4'b0000, 32'h0};

    rst = 1'b1; job_valid = 1'b0; job_diff = '0; abort = 1'b0; res_ready = 1'b0;
    wk_done = '0; wk_found = '0; wk_nonce = '0;
    tick(); tick();
    check("rst_job_ready", 32'(a_job_ready), 32'd0);
    check("rst_wk_start", 32'(a_wk_start), 32'd0);
    check("rst_wk_base", a_wk_base, 32'd0);
    check("rst_wk_diff", 32'(a_wk_diff), 32'd0);
    check("rst_wk_stop", 32'(a_wk_stop), 32'd0);
    check("rst_res_valid", 32'(a_res_valid), 32'd0);
    check("rst_res_found", 32'(a_res_found), 32'd0);
    check("rst_res_nonce", a_res_nonce, 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_job_ready_a", 32'(a_job_ready), 32'd1);
    check("idle_job_ready_b", 32'(b_job_ready), 32'd1);

    // Dispatch order, chunk bases and back-to-back restart
    accept_job(8'd8);
    check("run_wk_diff", 32'(a_wk_diff), 32'd8);
    check("run_busy", 32'(a_busy), 32'd1);
    check("run_job_ready", 32'(a_job_ready), 32'd0);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("tbl%0d_start_a", k), 32'(a_wk_start), 32'(tbl[k].start_a));
      check($sformatf("tbl%0d_start_b", k), 32'(b_wk_start), 32'(tbl[k].start_b));
      if (tbl[k].start_a != '0) check($sformatf("tbl%0d_base_a", k), a_wk_base, tbl[k].base_a);
      if (tbl[k].start_b != '0) check($sformatf("tbl%0d_base_b", k), b_wk_base, tbl[k].base_b);
      wk_done = tbl[k].done;
      tick();
      wk_done = '0;
    end

    // Worker 2 finds while the rest run
    wk_done = 4'b0100; wk_found = 4'b0100; wk_nonce[64 +: 32] = 32'h0002_1234;
    tick();
    wk_done = '0; wk_found = '0;
    check("find_stop_a", 32'(a_wk_stop), 32'd1);
    check("find_stop_b", 32'(b_wk_stop), 32'd1);
    check("find_no_start", 32'(a_wk_start), 32'd0);
    check("find_no_res_yet", 32'(a_res_valid), 32'd0);
    wk_done = 4'b1011; wk_found = 4'b0001; wk_nonce[0 +: 32] = 32'h0000_0099;
    tick();
    wk_done = '0; wk_found = '0;
    wait_res(1'b0, 4, ok);
    check("find_res_seen", 32'(ok), 32'd1);
    check("find_res_found", 32'(a_res_found), 32'd1);
    check("find_res_nonce", a_res_nonce, 32'h0002_1234);
    check("find_stop_low", 32'(a_wk_stop), 32'd0);
    check("find_res_b", b_res_nonce, 32'h0002_1234);
    job_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("stall_res_valid", 32'(a_res_valid), 32'd1);
      check("stall_res_nonce", a_res_nonce, 32'h0002_1234);
      check("stall_job_ready", 32'(a_job_ready), 32'd0);
      tick();
    end
    job_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("ack_res_valid", 32'(a_res_valid), 32'd0);
    check("ack_job_ready", 32'(a_job_ready), 32'd1);
    check("ack_busy", 32'(a_busy), 32'd0);
    check("ack_busy_b", 32'(b_busy), 32'd0);

    // Exhaustion with 30-bit chunks
    rst = 1'b1; tick(); rst = 1'b0; tick();
    accept_job(8'h20);
    nstarts = 0;
    for (int k = 0; k < 4; k++) begin
      nstarts += $countones(b_wk_start);
      tick();
    end
    wk_done = 4'b1111;
    nstarts += $countones(b_wk_start);
    tick();
    wk_done = '0;
    check("exh_a_restart", 32'(a_wk_start), 32'b0001);
    check("exh_a_base", a_wk_base, 32'h0004_0000);
    ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nstarts += $countones(b_wk_start);
      if (b_res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("exh_res_seen", 32'(ok), 32'd1);
    check("exh_starts", 32'(nstarts), 32'd4);
    check("exh_res_found", 32'(b_res_found), 32'd0);
    check("exh_res_nonce", b_res_nonce, 32'hFFFF_FFFF);
    check("exh_wk_diff", 32'(b_wk_diff), 32'h20);
`ifdef NONCE_SCHED_STATS_EN
    check("exh_stat", b_stat, 32'd4);
`endif
    res_ready = 1'b1; tick(); res_ready = 1'b0; tick();
`ifdef NONCE_SCHED_STATS_EN
    check("idle_stat_hold", b_stat, 32'd4);
`endif
    accept_job(8'h20);
`ifdef NONCE_SCHED_STATS_EN
    check("new_job_stat", b_stat, 32'd0);
`endif
    check("new_job_start", 32'(b_wk_start), 32'b0001);

    // Mid-job reset, then a same-cycle tie between workers 1 and 3
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_start", 32'(a_wk_start), 32'd0);
    check("midrst_diff", 32'(a_wk_diff), 32'd0);
    check("midrst_job_ready", 32'(a_job_ready), 32'd0);
`ifdef NONCE_SCHED_STATS_EN
    check("midrst_stat", a_stat, 32'd0);
`endif
    rst = 1'b0; tick();
    accept_job(8'd8);
    for (int k = 0; k < 4; k++) tick();
    wk_done = 4'b1010; wk_found = 4'b1010;
    wk_nonce[32 +: 32] = 32'h0000_0010; wk_nonce[96 +: 32] = 32'h0000_0020;
    tick();
    wk_done = 4'b0101; wk_found = '0;
    check("tie_stop", 32'(a_wk_stop), 32'd1);
    tick();
    wk_done = '0;
    wait_res(1'b0, 4, ok);
    check("tie_res_seen", 32'(ok), 32'd1);
    check("tie_res_found", 32'(a_res_found), 32'd1);
    check("tie_res_nonce", a_res_nonce, 32'h0000_0010);
    abort = 1'b1; tick(); abort = 1'b0;
    check("rep_abort_valid", 32'(a_res_valid), 32'd0);
    check("rep_abort_ready", 32'(a_job_ready), 32'd1);

    // Abort five cycles into a job
    accept_job(8'd8);
    for (int k = 0; k < 4; k++) tick();
    abort = 1'b1;
    tick();
    check("abort_stop", 32'(a_wk_stop), 32'd1);
    check("abort_busy", 32'(a_busy), 32'd1);
    tick();
    abort = 1'b0;
    check("abort_no_start", 32'(a_wk_start), 32'd0);
    check("abort_stop_held", 32'(a_wk_stop), 32'd1);
    wk_done = 4'b1111;
    tick();
    wk_done = '0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("abort_no_res", 32'(a_res_valid), 32'd0);
      if (a_job_ready === 1'b1) rdy_seen = 1'b1;
      tick();
    end
    check("abort_ready_back", 32'(rdy_seen), 32'd1);
    check("abort_stop_low", 32'(a_wk_stop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/nonce_scheduler.md
# nonce_scheduler

Job-level controller that shares one nonce search across `NUM_WORKERS` hash workers. It accepts a difficulty byte from the host, carves the 32-bit nonce space into fixed chunks, and dispatches them to idle workers. It collects worker completions and stops all workers on the first golden nonce. It reports a single result per job, either found or exhausted. It sits between the host/UART job interface and the array of per-worker SHA-256 nonce search engines.

## Interface
- `NUM_WORKERS`, 4: number of workers, 1..16.
- `CHUNK_BITS`, 16: chunk size is 2^CHUNK_BITS nonces, 1..31.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  host offers a job.
- `job_ready`  out  1  high only in IDLE.
- `job_diff`  in  8  difficulty; target = all-ones >> job_diff.
- `abort`  in  1  level; cancel the current job.
- `wk_start`  out  NUM_WORKERS  one-hot, one-cycle start pulse.
- `wk_base`  out  32  first nonce of the chunk; valid with `wk_start`.
- `wk_diff`  out  8  latched job difficulty, held for the whole job.
- `wk_stop`  out  1  broadcast stop; workers finish early and pulse done.
- `wk_done`  in  NUM_WORKERS  per-worker one-cycle completion pulse.
- `wk_found`  in  NUM_WORKERS  qualifies `wk_done`: golden nonce found.
- `wk_nonce`  in  32*NUM_WORKERS  worker i's golden nonce in bits [32i+31:32i].
- `res_valid`  out  1  result available; held until accepted.
- `res_ready`  in  1  host accepts the result.
- `res_found`  out  1  1 = golden nonce, 0 = space exhausted.
- `res_nonce`  out  32  golden nonce, or 0xFFFFFFFF when not found.
- `busy`  out  1  any state other than IDLE.

## Operation
- States: IDLE, RUN, DRAIN, REPORT.
- Internal registers:
  - `busy_vec[NUM_WORKERS]` tracks which workers are busy.
  - `next_base[32]` holds the next chunk base.
  - `exhausted` is set when `next_base` carries out of bit 31.
- IDLE:
  - `job_ready`=1.
  - On `job_valid`: latch `job_diff`, clear `next_base`, `exhausted`, `busy_vec` and the found flag, then go to RUN.
- RUN, dispatch:
  - Each cycle where `!exhausted` and some `busy_vec` bit is 0, start the lowest-index idle worker.
  - Drive its `wk_start` bit with `wk_base`=`next_base`, set its busy bit, and add 2^CHUNK_BITS to `next_base`.
  - At most one start per cycle.
- RUN, completion:
  - Every `wk_done` bit clears its busy bit in the same edge.
  - `wk_done` for a non-busy worker is ignored.
  - If one or more done-with-found arrive in a cycle, the lowest index wins. Latch its `wk_nonce` and go to DRAIN.
  - No dispatch occurs in that cycle or after it.
- RUN exit without a find: if `exhausted` and `busy_vec`==0, go to REPORT with `res_found`=0 and `res_nonce`=0xFFFFFFFF.
- DRAIN:
  - `wk_stop`=1 (level) until `busy_vec`==0. Later `wk_found` pulses are ignored.
  - Then go to REPORT, or to IDLE if entered via abort.
- REPORT:
  - `res_valid`=1, with `res_found`/`res_nonce` stable.
  - Go to IDLE on the cycle `res_ready`=1.
- `abort`:
  - In RUN: go to DRAIN, flagged as aborted, so no result is produced.
  - In REPORT: drop the result and go to IDLE.
  - In IDLE or DRAIN: no effect.
- `abort` and a found in the same cycle: abort wins.
- A start and a done for the same worker cannot coincide, because a start only targets a worker whose busy bit was already clear.
- With `CHUNK_BITS`=31 there are exactly 2 chunks. The carry-out sets `exhausted` after the second dispatch.

## Timing
- Reset values:
  - State IDLE. `job_ready` is 0 during `rst` and 1 from the first cycle after it.
  - `wk_start`=0, `wk_base`=0, `wk_diff`=0, `wk_stop`=0.
  - `res_valid`=0, `res_found`=0, `res_nonce`=0, `busy`=0.
- All outputs are registered or decoded from the state register only. There are no combinational input-to-output paths.
- Job accepted at edge T:
  - First `wk_start` in cycle T+1, worker 0, base 0.
  - Worker k starts in cycle T+1+k with base k·2^CHUNK_BITS.
- Found `wk_done` sampled at edge D:
  - `wk_stop` high in cycle D+1.
  - If no other worker is busy, `res_valid` is high in cycle D+2. Otherwise `res_valid` rises one cycle after the last busy worker's done.
- A worker freed by done at edge D can be restarted in cycle D+1 (back-to-back chunks).
- `rst` mid-job returns to reset values in one edge. Workers must also be reset by `rst`.

## Configuration
- `NONCE_SCHED_STATS_EN`
  - Defined: adds output `stat_chunks` (32 bits), the count of `wk_start` pulses in the current job.
    - Cleared on job acceptance and by `rst`.
    - Saturates at 0xFFFFFFFF.
    - Holds its value through REPORT and IDLE.
  - Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- NUM_WORKERS=4, CHUNK_BITS=16, job_diff=8; worker 2 returns found with nonce 0x00021234 while the others run → wk_stop for the rest, res_valid with res_found=1, res_nonce=0x00021234.
- CHUNK_BITS=30, workers complete with no find → exactly 4 starts (bases 0, 0x40000000, 0x80000000, 0xC0000000), then res_found=0, res_nonce=0xFFFFFFFF.
- Workers 1 and 3 pulse done+found in the same cycle (nonces 0x10, 0x20) → res_nonce=0x10.
- abort asserted 5 cycles after job accept → wk_stop until all done, no res_valid, job_ready returns to 1.
- res_ready held low 10 cycles in REPORT → res_valid and outputs stable; job_valid is ignored until the handshake completes.
- With NONCE_SCHED_STATS_EN and CHUNK_BITS=30, no find → stat_chunks=4 at REPORT; reset to 0 on the next job accept.
